// File: rtl/moore_token_recognizer.sv
// ---------------------------------------------------------------------------
// moore_token_recognizer
//   Moore-style token recogniser placed between the character decoder and the
//   token consumer. Walks the S0..S8 character-sequence graph one qualified
//   character per cycle and reports the current state code on saida.
//   Terminal states (S6/S8 accept, S7 error) restart a new word on the next
//   valid character. Word length is counted and saturates at MAX_LEN. Once
//   the count is full, any further step into S1..S5 is forced to S7.
//
// Ports
//   clk            in   1       clock, rising edge
//   rst            in   1       asynchronous reset, active low
//   clear          in   1       synchronous restart to S0 (beats entrada_valid)
//   entrada_valid  in   1       entrada carries a character this cycle
//   entrada        in   CHAR_W  input character
//   saida          out  4       state code S0..S5=0..5, S6=8, S7=9, S8=10
//   accept         out  1       state is S6 or S8
//   error          out  1       state is S7
//   done           out  1       one-cycle pulse on first cycle in a terminal state
//   len            out  CNT_W   characters consumed in the current word
// ---------------------------------------------------------------------------
module moore_token_recognizer #(
  parameter int                CHAR_W  = 8,
  parameter logic [CHAR_W-1:0] C1      = 8'hF8,
  parameter logic [CHAR_W-1:0] C2      = 8'hC0,
  parameter logic [CHAR_W-1:0] C3      = 8'hDC,
  parameter logic [CHAR_W-1:0] C4      = 8'hEA,
  parameter logic [CHAR_W-1:0] C5      = 8'hCE,
  parameter logic [CHAR_W-1:0] C6      = 8'hF1,
  parameter logic [CHAR_W-1:0] C7      = 8'hD5,
  parameter logic [CHAR_W-1:0] C8      = 8'hE3,
  parameter int                MAX_LEN = 15,
  localparam int               CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              entrada_valid,
  input  logic [CHAR_W-1:0] entrada,
  output logic [3:0]        saida,
  output logic              accept,
  output logic              error,
  output logic              done,
  output logic [CNT_W-1:0]  len
);

  // State encoding equals the published saida code, so saida is the register.
  localparam logic [3:0] S0 = 4'd0;
  localparam logic [3:0] S1 = 4'd1;
  localparam logic [3:0] S2 = 4'd2;
  localparam logic [3:0] S3 = 4'd3;
  localparam logic [3:0] S4 = 4'd4;
  localparam logic [3:0] S5 = 4'd5;
  localparam logic [3:0] S6 = 4'd8;
  localparam logic [3:0] S7 = 4'd9;
  localparam logic [3:0] S8 = 4'd10;

  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_LEN);

  logic [3:0]       state, nstate;
  logic [CNT_W-1:0] len_q, nlen, base;
  logic             done_q, ndone;
  logic             terminal;
  logic [3:0]       row, tgt;
  logic             hit;

  function automatic logic is_term(input logic [3:0] s);
    return (s == S6) || (s == S7) || (s == S8);
  endfunction

  assign terminal = is_term(state);
  // A terminal state evaluates the incoming character as the start of a new word.
  assign row      = terminal ? S0 : state;

  // Row lookup. Checks run in table order so that, with duplicated codes,
  // the later-listed transition overrides the earlier one.
  always_comb begin
    hit = 1'b0;
    tgt = S0;
    case (row)
      S0: begin
        if (entrada == C1) begin hit = 1'b1; tgt = S1; end
        if (entrada == C2) begin hit = 1'b1; tgt = S2; end
        if (entrada == C3) begin hit = 1'b1; tgt = S3; end
        if (entrada == C4) begin hit = 1'b1; tgt = S4; end
        if (entrada == C5) begin hit = 1'b1; tgt = S5; end
      end
      S1: begin
        if (entrada == C2) begin hit = 1'b1; tgt = S2; end
        if (entrada == C6) begin hit = 1'b1; tgt = S6; end
        if (entrada == C3 || entrada == C4 || entrada == C5 || entrada == C7) begin
          hit = 1'b1; tgt = S7;
        end
      end
      S2: begin
        if (entrada == C1) begin hit = 1'b1; tgt = S1; end
        if (entrada == C3) begin hit = 1'b1; tgt = S3; end
        if (entrada == C6) begin hit = 1'b1; tgt = S6; end
        if (entrada == C4 || entrada == C5 || entrada == C7) begin
          hit = 1'b1; tgt = S7;
        end
      end
      S3: begin
        if (entrada == C2) begin hit = 1'b1; tgt = S2; end
        if (entrada == C4) begin hit = 1'b1; tgt = S4; end
        if (entrada == C6) begin hit = 1'b1; tgt = S6; end
        if (entrada == C1 || entrada == C5 || entrada == C7) begin
          hit = 1'b1; tgt = S7;
        end
      end
      S4: begin
        if (entrada == C3) begin hit = 1'b1; tgt = S3; end
        if (entrada == C5) begin hit = 1'b1; tgt = S5; end
        if (entrada == C8) begin hit = 1'b1; tgt = S8; end
        if (entrada == C1 || entrada == C2 || entrada == C7) begin
          hit = 1'b1; tgt = S7;
        end
      end
      S5: begin
        if (entrada == C4) begin hit = 1'b1; tgt = S4; end
        if (entrada == C8) begin hit = 1'b1; tgt = S8; end
        if (entrada == C1 || entrada == C2 || entrada == C3 || entrada == C7) begin
          hit = 1'b1; tgt = S7;
        end
      end
      default: begin
        hit = 1'b0;
        tgt = S0;
      end
    endcase
  end

  always_comb begin
    nstate = state;
    nlen   = len_q;
    ndone  = 1'b0;
    base   = terminal ? '0 : len_q;
    if (clear) begin
      nstate = S0;
      nlen   = '0;
    end else if (entrada_valid) begin
      if (!hit) begin
        // Unlisted character: hold mid-word, abandon a finished word.
        if (terminal) begin
          nstate = S0;
          nlen   = '0;
        end
      end else begin
        if (base == MAXC) begin
          // Full word: stepping to S1..S5 becomes an error; length saturates.
          nstate = is_term(tgt) ? tgt : S7;
          nlen   = MAXC;
        end else begin
          nstate = tgt;
          nlen   = base + CNT_W'(1);
        end
        ndone = !terminal && is_term(nstate);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= nstate;
      len_q  <= nlen;
      done_q <= ndone;
    end
  end

  assign saida  = state;
  assign accept = (state == S6) || (state == S8);
  assign error  = (state == S7);
  assign done   = done_q;
  assign len    = len_q;

endmodule

// File: tb/tb_moore_token_recognizer.sv
// ---------------------------------------------------------------------------
// tb_moore_token_recognizer
//   Bench for moore_token_recognizer. Two instances share the stimulus: the
//   default MAX_LEN=15 and a MAX_LEN=3 copy for overflow behaviour. A
//   table-driven word model predicts every output. A compare process checks
//   both instances on each falling edge. Directed sequences add literal
//   expectations.
// ---------------------------------------------------------------------------
module tb_moore_token_recognizer;

  localparam logic [7:0] K1 = 8'hF8, K2 = 8'hC0, K3 = 8'hDC, K4 = 8'hEA;
  localparam logic [7:0] K5 = 8'hCE, K6 = 8'hF1, K7 = 8'hD5, K8 = 8'hE3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] entrada = 8'h00;

  logic [3:0] saida, saida3;
  logic       accept, accept3, error, error3, done, done3;
  logic [3:0] len;
  logic [1:0] len3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  moore_token_recognizer #(.CHAR_W(8), .MAX_LEN(15)) dut (
    .clk(clk), .rst(rst), .clear(clear), .entrada_valid(valid), .entrada(entrada),
    .saida(saida), .accept(accept), .error(error), .done(done), .len(len)
  );

  moore_token_recognizer #(.CHAR_W(8), .MAX_LEN(3)) dut3 (
    .clk(clk), .rst(rst), .clear(clear), .entrada_valid(valid), .entrada(entrada),
    .saida(saida3), .accept(accept3), .error(error3), .done(done3), .len(len3)
  );

  // ---------------- word model ----------------
  typedef struct packed { int st; int len; bit done; } mstate_t;

  logic [7:0] codes [1:8];
  int         tr [0:5][1:8];   // -1 = unlisted, else target saida code
  int         maxl [2];
  mstate_t    m [2];

  initial begin
    codes[1] = K1; codes[2] = K2; codes[3] = K3; codes[4] = K4;
    codes[5] = K5; codes[6] = K6; codes[7] = K7; codes[8] = K8;
    maxl[0] = 15; maxl[1] = 3;
    for (int r = 0; r < 6; r++)
      for (int c = 1; c <= 8; c++) tr[r][c] = -1;
    tr[0][1] = 1; tr[0][2] = 2; tr[0][3] = 3; tr[0][4] = 4; tr[0][5] = 5;
    tr[1][2] = 2; tr[1][6] = 8; tr[1][3] = 9; tr[1][4] = 9; tr[1][5] = 9; tr[1][7] = 9;
    tr[2][1] = 1; tr[2][3] = 3; tr[2][6] = 8; tr[2][4] = 9; tr[2][5] = 9; tr[2][7] = 9;
    tr[3][2] = 2; tr[3][4] = 4; tr[3][6] = 8; tr[3][1] = 9; tr[3][5] = 9; tr[3][7] = 9;
    tr[4][3] = 3; tr[4][5] = 5; tr[4][8] = 10; tr[4][1] = 9; tr[4][2] = 9; tr[4][7] = 9;
    tr[5][4] = 4; tr[5][8] = 10; tr[5][1] = 9; tr[5][2] = 9; tr[5][3] = 9; tr[5][7] = 9;
  end

  function automatic mstate_t step(mstate_t cur, int mx, bit cl, bit v, logic [7:0] c);
    mstate_t n;
    int ci, rw, tg, base;
    bit term;
    n = cur;
    n.done = 1'b0;
    if (cl) begin
      n.st = 0; n.len = 0;
      return n;
    end
    if (!v) return n;
    term = (cur.st >= 8);
    ci = 0;
    for (int i = 1; i <= 8; i++) if (c == codes[i]) ci = i;
    rw = term ? 0 : cur.st;
    tg = (ci == 0) ? -1 : tr[rw][ci];
    if (tg < 0) begin
      if (term) begin n.st = 0; n.len = 0; end
      return n;
    end
    base = term ? 0 : cur.len;
    if (tg >= 1 && tg <= 5 && base == mx) begin
      n.st = 9; n.len = mx;
    end else begin
      n.st = tg;
      n.len = (base + 1 > mx) ? mx : base + 1;
    end
    n.done = !term && (n.st >= 8);
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) m[k] <= '{st: 0, len: 0, done: 1'b0};
    end else begin
      for (int k = 0; k < 2; k++) m[k] <= step(m[k], maxl[k], clear, valid, entrada);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("cmp_saida",   saida,   m[0].st);
      chk("cmp_accept",  accept,  (m[0].st == 8 || m[0].st == 10) ? 1 : 0);
      chk("cmp_error",   error,   (m[0].st == 9) ? 1 : 0);
      chk("cmp_done",    done,    m[0].done);
      chk("cmp_len",     len,     m[0].len);
      chk("cmp3_saida",  saida3,  m[1].st);
      chk("cmp3_accept", accept3, (m[1].st == 8 || m[1].st == 10) ? 1 : 0);
      chk("cmp3_error",  error3,  (m[1].st == 9) ? 1 : 0);
      chk("cmp3_done",   done3,   m[1].done);
      chk("cmp3_len",    len3,    m[1].len);
    end
  end

  // One call = exactly one rising edge with the given inputs applied.
  task automatic put(input bit cl, input bit v, input logic [7:0] c);
    @(negedge clk);
    #1;
    clear = cl; valid = v; entrada = c;
    @(posedge clk);
    #1;
    clear = 1'b0; valid = 1'b0;
  endtask

  task automatic expect_main(input string nm, input int sa, input int ln,
                             input int ac, input int er, input int dn);
    chk({nm, "_saida"},  saida,  sa);
    chk({nm, "_len"},    len,    ln);
    chk({nm, "_accept"}, accept, ac);
    chk({nm, "_error"},  error,  er);
    chk({nm, "_done"},   done,   dn);
  endtask

  task automatic mid_cycle_reset(input string nm);
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk({nm, "_saida"}, saida, 0);
    chk({nm, "_len"},   len,   0);
    chk({nm, "_done"},  done,  0);
    rst = 1'b1;
  endtask

  initial begin
    #3;
    chk("rst_saida", saida, 0);
    chk("rst_len", len, 0);
    chk("rst_done", done, 0);
    #9;
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_main("reset", 0, 0, 0, 0, 0);

    // async reset mid-word, from S2
    put(0, 1, K2);
    expect_main("s2", 2, 1, 0, 0, 0);
    mid_cycle_reset("arst_s2");

    // C1,C6 -> S6 accept, done for one cycle
    put(0, 1, K1);
    expect_main("t2a", 1, 1, 0, 0, 0);
    put(0, 1, K6);
    expect_main("t2b", 8, 2, 1, 0, 1);
    chk("pin_model_s6", m[0].st, 8);
    chk("pin_model_len2", m[0].len, 2);
    put(0, 0, K1);
    expect_main("t2c", 8, 2, 1, 0, 0);

    // restart from terminal: C4,C8 then C2
    put(0, 1, K4);
    expect_main("t3a", 4, 1, 0, 0, 0);
    put(0, 1, K8);
    expect_main("t3b", 10, 2, 1, 0, 1);
    put(0, 1, K2);
    expect_main("t3c", 2, 1, 0, 0, 0);

    // C1,C3 -> S7, then unlisted char abandons the word
    put(1, 0, 8'h00);
    expect_main("clr", 0, 0, 0, 0, 0);
    put(0, 1, K1);
    put(0, 1, K3);
    expect_main("t4a", 9, 2, 0, 1, 1);
    chk("pin_model_s7", m[0].st, 9);
    put(0, 1, 8'h00);
    expect_main("t4b", 0, 0, 0, 0, 0);

    // MAX_LEN=3 copy: C1,C2,C1,C2 -> 1,2,1,9 with len 1,2,3,3
    put(1, 0, 8'h00);
    put(0, 1, K1);
    chk("t5a_saida", saida3, 1); chk("t5a_len", len3, 1);
    put(0, 1, K2);
    chk("t5b_saida", saida3, 2); chk("t5b_len", len3, 2);
    put(0, 1, K1);
    chk("t5c_saida", saida3, 1); chk("t5c_len", len3, 3);
    put(0, 1, K2);
    chk("t5d_saida", saida3, 9); chk("t5d_len", len3, 3);
    chk("t5d_done", done3, 1);
    chk("pin_model3_s7", m[1].st, 9);
    chk("pin_model3_len", m[1].len, 3);

    // hold and clear behaviour
    put(1, 0, 8'h00);
    put(0, 1, K2);
    expect_main("t6a", 2, 1, 0, 0, 0);
    put(0, 0, K1);
    expect_main("t6b", 2, 1, 0, 0, 0);
    put(0, 1, 8'h00);
    expect_main("t6c", 2, 1, 0, 0, 0);
    put(1, 1, K3);
    expect_main("t6d", 0, 0, 0, 0, 0);

    // done in flight is dropped by reset
    put(0, 1, K1);
    put(0, 1, K6);
    expect_main("pre_drop", 8, 2, 1, 0, 1);
    mid_cycle_reset("arst_done");

    // MAX_LEN=15 overflow: 15 alternating C1/C2, then C2 forces S7
    put(1, 0, 8'h00);
    for (int i = 0; i < 15; i++) put(0, 1, (i % 2 == 0) ? K1 : K2);
    expect_main("ovf_full", 1, 15, 0, 0, 0);
    put(0, 1, K2);
    expect_main("ovf_err", 9, 15, 0, 1, 1);

    // pseudo-random walk, checked by the compare process
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [7:0] c;
      r = $urandom_range(0, 9);
      if (r < 8) c = codes[r + 1];
      else if (r == 8) c = 8'h00;
      else c = 8'h5A;
      put(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), c);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
